// File: rtl/bayer_pkg.sv
// Shared types and helpers for the 3x3 bilinear Bayer demosaic.
package bayer_pkg;

    typedef enum logic [1:0] {
        CfaRggb = 2'd0,
        CfaGrbg = 2'd1,
        CfaGbrg = 2'd2,
        CfaBggr = 2'd3
    } cfa_e;

    // Bit 1 is row parity, bit 0 column parity, relative to an RGGB origin.
    typedef enum logic [1:0] {
        SiteR  = 2'd0,
        SiteGr = 2'd1,
        SiteGb = 2'd2,
        SiteB  = 2'd3
    } site_e;

    localparam int unsigned BAYER_LAT = 5;
    localparam int unsigned AVG_W     = 18;

    function automatic logic [AVG_W-1:0] round_avg(input logic [AVG_W-1:0] sum,
                                                   input logic [1:0]       sh);
        logic [AVG_W-1:0] half;
        half = (AVG_W'(1) << sh) >> 1;
        return (sum + half) >> sh;
    endfunction

endpackage

// File: rtl/bayer_demosaic_line_delay.sv
// One line of pixel storage: simple dual-port RAM with a registered, read-before-write port.
module line_delay #(
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_HRES = 2048,
    localparam int unsigned AW      = (MAX_HRES > 1) ? $clog2(MAX_HRES) : 1
) (
    input  logic          clock,
    input  logic          clken,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem_q [MAX_HRES];

    always_ff @(posedge clock) begin
        if (clken) begin
            dout        <= mem_q[addr];
            mem_q[addr] <= din;
        end
    end

endmodule

// File: rtl/bayer_demosaic.sv
// 3x3 bilinear Bayer demosaic with mirrored border columns and a fixed 5-cycle latency.
// Optional feature: BAYER_RT_PATTERN_EN adds pattern_i, latched on each vs active edge.
module bayer_demosaic
    import bayer_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_HRES = 2048,
    parameter int unsigned PATTERN  = 3,
    parameter int unsigned VS_POL   = 0
) (
    input  logic          pix_clk,
    input  logic          rst_n,
    input  logic          vs_i,
    input  logic          de_i,
    input  logic [DW-1:0] data_i,
`ifdef BAYER_RT_PATTERN_EN
    input  logic [1:0]    pattern_i,
`endif
    output logic          vs_o,
    output logic          de_o,
    output logic [DW-1:0] r_o,
    output logic [DW-1:0] g_o,
    output logic [DW-1:0] b_o,
    output logic          ovf_o
);

    localparam int unsigned AW = (MAX_HRES > 1) ? $clog2(MAX_HRES) : 1;
    localparam int unsigned XW = $clog2(MAX_HRES + 1);
    localparam logic [XW-1:0] X_MAX = XW'(MAX_HRES);
    localparam logic VS_ACT = (VS_POL != 0);

    logic          vs_act, vs_act_q, vs_edge, de_q, de_fall, wr_en, val_in;
    logic [XW-1:0] x_q, x_d;
    logic [15:0]   y_q, y_d;
    logic          armed_q, ovf_q, ovf_d;
    cfa_e          phase;
    site_e         site_in;

    assign vs_act  = (vs_i == VS_ACT);
    assign vs_edge = vs_act & ~vs_act_q;
    assign de_fall = de_q & ~de_i;
    assign wr_en   = de_i & (x_q != X_MAX);

`ifdef BAYER_RT_PATTERN_EN
    cfa_e phase_q;
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= CfaRggb;
        end else if (vs_edge) begin
            phase_q <= cfa_e'(pattern_i);
        end
    end
    assign phase = phase_q;
`else
    assign phase = cfa_e'(2'(PATTERN));
`endif

    // The tag carries the site of the pixel one row up, which becomes the window centre.
    assign site_in = site_e'({~y_q[0], x_q[0]} ^ phase);
    assign val_in  = de_i & armed_q & (y_q >= 16'd2);

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        ovf_d = ovf_q;
        if (!de_i) begin
            x_d = '0;
        end else if (x_q != X_MAX) begin
            x_d = x_q + XW'(1);
        end
        if (vs_edge) begin
            y_d = '0;
        end else if (de_fall && (y_q != '1)) begin
            y_d = y_q + 16'd1;
        end
        if (vs_edge) begin
            ovf_d = 1'b0;
        end else if (de_i && (x_q == X_MAX)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_act_q <= 1'b0;
            de_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            armed_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            vs_act_q <= vs_act;
            de_q     <= de_i;
            x_q      <= x_d;
            y_q      <= y_d;
            armed_q  <= armed_q | vs_edge;
            ovf_q    <= ovf_d;
        end
    end

    logic [DW-1:0] mid_rd, top_rd;
    logic [DW-1:0] cur1_q, cur2_q, mid2_q;
    logic          de1_q, de2_q, val1_q, val2_q, wr1_q;
    logic [AW-1:0] addr1_q;
    site_e         site1_q, site2_q, site_t0_q, site_t1_q;
    logic [DW-1:0] top_q [3];
    logic [DW-1:0] mid_q [3];
    logic [DW-1:0] bot_q [3];
    logic [2:0]    de_t_q;
    logic [1:0]    val_t_q;
    logic [BAYER_LAT-1:0] vs_pipe_q;

    line_delay #(.DW(DW), .MAX_HRES(MAX_HRES)) u_ld1 (
        .clock (pix_clk),
        .clken (wr_en),
        .addr  (x_q[AW-1:0]),
        .din   (data_i),
        .dout  (mid_rd)
    );

    line_delay #(.DW(DW), .MAX_HRES(MAX_HRES)) u_ld2 (
        .clock (pix_clk),
        .clken (wr1_q),
        .addr  (addr1_q),
        .din   (mid_rd),
        .dout  (top_rd)
    );

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            cur1_q    <= '0;
            cur2_q    <= '0;
            mid2_q    <= '0;
            de1_q     <= 1'b0;
            de2_q     <= 1'b0;
            val1_q    <= 1'b0;
            val2_q    <= 1'b0;
            wr1_q     <= 1'b0;
            addr1_q   <= '0;
            site1_q   <= SiteR;
            site2_q   <= SiteR;
            site_t0_q <= SiteR;
            site_t1_q <= SiteR;
            for (int i = 0; i < 3; i++) begin
                top_q[i] <= '0;
                mid_q[i] <= '0;
                bot_q[i] <= '0;
            end
            de_t_q    <= '0;
            val_t_q   <= '0;
            vs_pipe_q <= {BAYER_LAT{~VS_ACT}};
        end else begin
            cur1_q    <= data_i;
            de1_q     <= de_i;
            val1_q    <= val_in;
            site1_q   <= site_in;
            wr1_q     <= wr_en;
            addr1_q   <= x_q[AW-1:0];
            cur2_q    <= cur1_q;
            mid2_q    <= mid_rd;
            de2_q     <= de1_q;
            val2_q    <= val1_q;
            site2_q   <= site1_q;
            // Taps shift every cycle so blanking flushes through as de=0 border columns.
            top_q[0]  <= top_rd;
            top_q[1]  <= top_q[0];
            top_q[2]  <= top_q[1];
            mid_q[0]  <= mid2_q;
            mid_q[1]  <= mid_q[0];
            mid_q[2]  <= mid_q[1];
            bot_q[0]  <= cur2_q;
            bot_q[1]  <= bot_q[0];
            bot_q[2]  <= bot_q[1];
            de_t_q    <= {de_t_q[1:0], de2_q};
            val_t_q   <= {val_t_q[0], val2_q};
            site_t0_q <= site2_q;
            site_t1_q <= site_t0_q;
            vs_pipe_q <= {vs_pipe_q[BAYER_LAT-2:0], vs_i};
        end
    end

    function automatic logic [DW-1:0] avg4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c, input logic [DW-1:0] d);
        logic [AVG_W-1:0] t;
        t = round_avg(AVG_W'(a) + AVG_W'(b) + AVG_W'(c) + AVG_W'(d), 2'd2);
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] avg2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [AVG_W-1:0] t;
        t = round_avg(AVG_W'(a) + AVG_W'(b), 2'd1);
        return t[DW-1:0];
    endfunction

    logic [DW-1:0] tl, tr, ml, mr, bl, br, g4, d4, h2, v2;
    logic [DW-1:0] r_d, g_d, b_d, r_q, g_q, b_q;
    logic          de_o_q;

    always_comb begin
        // Index 2 is the left column, 0 the right; a missing side mirrors the other.
        tl = de_t_q[2] ? top_q[2] : top_q[0];
        tr = de_t_q[0] ? top_q[0] : top_q[2];
        ml = de_t_q[2] ? mid_q[2] : mid_q[0];
        mr = de_t_q[0] ? mid_q[0] : mid_q[2];
        bl = de_t_q[2] ? bot_q[2] : bot_q[0];
        br = de_t_q[0] ? bot_q[0] : bot_q[2];
        g4 = avg4(top_q[1], bot_q[1], ml, mr);
        d4 = avg4(tl, tr, bl, br);
        h2 = avg2(ml, mr);
        v2 = avg2(top_q[1], bot_q[1]);
        r_d = mid_q[1];
        g_d = g4;
        b_d = d4;
        unique case (site_t1_q)
            SiteR:  begin r_d = mid_q[1]; g_d = g4;       b_d = d4;       end
            SiteB:  begin r_d = d4;       g_d = g4;       b_d = mid_q[1]; end
            SiteGr: begin r_d = h2;       g_d = mid_q[1]; b_d = v2;       end
            SiteGb: begin r_d = v2;       g_d = mid_q[1]; b_d = h2;       end
            default: ;
        endcase
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            de_o_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            de_o_q <= val_t_q[1];
        end
    end

    assign vs_o  = vs_pipe_q[BAYER_LAT-1];
    assign de_o  = de_o_q;
    assign r_o   = r_q;
    assign g_o   = g_q;
    assign b_o   = b_q;
    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_bayer_demosaic.sv
// Scoreboard bench for bayer_demosaic: BGGR, DW=8, MAX_HRES=2048, active-low vs.
module tb_bayer_demosaic;

    logic       pix_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       vs_i    = 1'b1;
    logic       de_i    = 1'b0;
    logic [7:0] data_i  = 8'd0;
`ifdef BAYER_RT_PATTERN_EN
    logic [1:0] pattern_i = 2'd3;
`endif
    logic       vs_o, de_o, ovf_o;
    logic [7:0] r_o, g_o, b_o;

    bayer_demosaic #(.DW(8), .MAX_HRES(2048), .PATTERN(3), .VS_POL(0)) dut (
        .pix_clk   (pix_clk),
        .rst_n     (rst_n),
        .vs_i      (vs_i),
        .de_i      (de_i),
        .data_i    (data_i),
`ifdef BAYER_RT_PATTERN_EN
        .pattern_i (pattern_i),
`endif
        .vs_o      (vs_o),
        .de_o      (de_o),
        .r_o       (r_o),
        .g_o       (g_o),
        .b_o       (b_o),
        .ovf_o     (ovf_o)
    );

    always #5 pix_clk = ~pix_clk;

    int cyc = 0;
    always @(posedge pix_clk) cyc <= cyc + 1;

    typedef struct {
        int cx;
        int cy;
        int r;
        int g;
        int b;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   img [0:7][0:7];
    int   gr  [0:7][0:7];
    int   gg  [0:7][0:7];
    int   gb  [0:7][0:7];
    int   l2_cyc = 0;
    bit   tchk = 1'b0;
    bit   first_seen = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int pix(input int x, input int y, input int w);
        if (x < 0) x = 1;
        else if (x >= w) x = w - 2;
        return img[y][x];
    endfunction

    task automatic push_rows(input int w, input int r0, input int r1);
        for (int cy = r0; cy <= r1; cy++) begin
            for (int cx = 0; cx < w; cx++) begin
                exp_t e;
                int   c, n, s, wv, ev, g4, d4, h2, v2, site;
                c    = pix(cx, cy, w);
                n    = pix(cx, cy - 1, w);
                s    = pix(cx, cy + 1, w);
                wv   = pix(cx - 1, cy, w);
                ev   = pix(cx + 1, cy, w);
                g4   = (n + s + wv + ev + 2) >> 2;
                d4   = (pix(cx - 1, cy - 1, w) + pix(cx + 1, cy - 1, w)
                        + pix(cx - 1, cy + 1, w) + pix(cx + 1, cy + 1, w) + 2) >> 2;
                h2   = (wv + ev + 1) >> 1;
                v2   = (n + s + 1) >> 1;
                site = (((cy & 1) << 1) | (cx & 1)) ^ 3;
                e.cx = cx;
                e.cy = cy;
                case (site)
                    0:       begin e.r = c;  e.g = g4; e.b = d4; end
                    3:       begin e.r = d4; e.g = g4; e.b = c;  end
                    1:       begin e.r = h2; e.g = c;  e.b = v2; end
                    default: begin e.r = v2; e.g = c;  e.b = h2; end
                endcase
                sbq.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic vs_pulse();
        vs_i = 1'b0;
        step();
        step();
        vs_i = 1'b1;
        repeat (3) step();
    endtask

    task automatic send_line(input int y, input int w);
        for (int x = 0; x < w; x++) begin
            de_i   = 1'b1;
            data_i = 8'(img[y][x]);
            if (y == 2 && x == 0) l2_cyc = cyc;
            step();
        end
        de_i   = 1'b0;
        data_i = 8'd0;
        repeat (4) step();
    endtask

    task automatic send_frame(input int w, input int v, input bit timing);
        push_rows(w, 1, v - 2);
        tchk       = timing;
        first_seen = 1'b0;
        vs_pulse();
        for (int y = 0; y < v; y++) send_line(y, w);
        repeat (8) step();
    endtask

    task automatic fill(input int kind);
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                case (kind)
                    0:       img[y][x] = 100;
                    1:       img[y][x] = (x == 3 && y == 3) ? 200 : 0;
                    2:       img[y][x] = (x < 6) ? 10 * x : 0;
                    3:       img[y][x] = (x * 37 + y * 53 + x * y * 11) & 255;
                    default: img[y][x] = 50;
                endcase
            end
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge pix_clk);
                if (rst_n && de_o) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_de_o got 1 want 0 at cycle %0d", cyc);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk($sformatf("r(%0d,%0d)", e.cx, e.cy), int'(r_o), e.r);
                        chk($sformatf("g(%0d,%0d)", e.cx, e.cy), int'(g_o), e.g);
                        chk($sformatf("b(%0d,%0d)", e.cx, e.cy), int'(b_o), e.b);
                        gr[e.cy][e.cx] = int'(r_o);
                        gg[e.cy][e.cx] = int'(g_o);
                        gb[e.cy][e.cx] = int'(b_o);
                        if (tchk && !first_seen) begin
                            first_seen = 1'b1;
                            chk("de_o_latency", cyc - l2_cyc, 5);
                        end
                    end
                end
            end
        join_none

        repeat (3) step();
        chk("rst_de_o", int'(de_o), 0);
        chk("rst_vs_o", int'(vs_o), 1);
        chk("rst_r_o", int'(r_o), 0);
        chk("rst_g_o", int'(g_o), 0);
        chk("rst_b_o", int'(b_o), 0);
        chk("rst_ovf_o", int'(ovf_o), 0);
        rst_n = 1'b1;
        step();

        // Lines before the first vs edge must produce nothing.
        fill(0);
        for (int y = 0; y < 4; y++) send_line(y, 8);
        repeat (8) step();

        send_frame(8, 6, 1'b1);
        chk("flat_r", gr[1][0], 100);
        chk("flat_g", gg[4][7], 100);
        chk("flat_b", gb[2][3], 100);

        fill(1);
        send_frame(8, 6, 1'b0);
        chk("imp_r_centre", gr[3][3], 200);
        chk("imp_r_left", gr[3][2], 100);
        chk("imp_r_right", gr[3][4], 100);
        chk("imp_g_centre", gg[3][3], 0);
        chk("imp_b_centre", gb[3][3], 0);
        chk("imp_r_diag", gr[2][2], 50);

        fill(2);
        send_frame(6, 4, 1'b0);
        chk("mir_r_x0", gr[1][0], 10);
        chk("mir_g_x5", gg[1][5], 45);
        chk("mir_b_x5", gb[1][5], 40);
        chk("mir_g_x0", gg[2][0], 5);
        chk("mir_r_x0_diag", gr[2][0], 10);

        fill(3);
        send_frame(8, 6, 1'b0);

        vs_pulse();
        for (int i = 0; i < 2049; i++) begin
            de_i   = 1'b1;
            data_i = 8'(i);
            step();
            if (i == 2047) chk("ovf_at_2048", int'(ovf_o), 0);
        end
        chk("ovf_at_2049", int'(ovf_o), 1);
        de_i = 1'b0;
        repeat (4) step();
        fill(0);
        send_line(1, 8);
        chk("ovf_sticky", int'(ovf_o), 1);
        vs_pulse();
        chk("ovf_cleared", int'(ovf_o), 0);

        // Reset during line 3, after row 1 has fully drained.
        fill(4);
        push_rows(8, 1, 1);
        tchk = 1'b0;
        vs_pulse();
        for (int y = 0; y < 3; y++) send_line(y, 8);
        for (int x = 0; x < 3; x++) begin
            de_i   = 1'b1;
            data_i = 8'(img[3][x]);
            step();
        end
        rst_n  = 1'b0;
        de_i   = 1'b0;
        data_i = 8'd0;
        #2;
        chk("mid_rst_de_o", int'(de_o), 0);
        chk("mid_rst_vs_o", int'(vs_o), 1);
        chk("mid_rst_r_o", int'(r_o), 0);
        chk("mid_rst_g_o", int'(g_o), 0);
        chk("mid_rst_b_o", int'(b_o), 0);
        chk("mid_rst_sb_empty", sbq.size(), 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        for (int y = 0; y < 4; y++) send_line(y, 8);
        repeat (8) step();
        send_frame(8, 5, 1'b0);

        for (int i = 0; i < 50 && sbq.size() != 0; i++) step();
        chk("sb_drain", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
